// File: rtl/dda_ctrl_pkg.sv
// Shared opcodes, FSM encoding and reset parameter image for the DDA control front-end.
package dda_ctrl_pkg;

  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_RUN  = 8'h02;
  localparam logic [7:0] OP_HALT = 8'h03;
  localparam logic [7:0] OP_SNAP = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } ctrl_state_e;

  // Lorenz defaults: word0 icx .. word6 dt (16-bit posits)
  localparam logic [111:0] DEFAULT_LORENZ_16 = 112'h0400_7300_5555_6A00_7240_14CD_C000;

  // Bit position of load byte k: words in ascending order, each word MSB byte first.
  function automatic int unsigned load_byte_lsb(input int unsigned k, input int unsigned bpw);
    int unsigned j;
    j = k % bpw;
    return (k + bpw - 1 - 2 * j) * 8;
  endfunction

endpackage

// File: rtl/dda_byte_ser.sv
// Parallel-load byte serializer: word 0 first, MSB byte first, valid/ready output.
module dda_byte_ser
  import dda_ctrl_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned NW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [NW*W-1:0] din,
  output logic [7:0]     out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           done_c
);

  localparam int unsigned TW = NW * W;
  localparam int unsigned NB = TW / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  logic [TW-1:0] sr;
  logic [TW-1:0] ord_c;
  logic [CW-1:0] cnt;
  logic          last_c;

  // Reverse word order so a plain MSB-first shift emits word 0 first.
  for (genvar k = 0; k < NW; k++) begin : g_ord
    assign ord_c[(NW-1-k)*W +: W] = din[k*W +: W];
  end

  assign out_data = sr[TW-1 -: 8];
  assign last_c   = (cnt == CW'(NB - 1));
  assign done_c   = out_valid && out_ready && last_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr        <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else if (load) begin
      sr        <= ord_c;
      out_valid <= 1'b1;
      cnt       <= '0;
    end else if (out_valid && out_ready) begin
      sr  <= sr << 8;
      cnt <= cnt + CW'(1);
      if (last_c) out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dda_ctrl.sv
// Byte-serial control front-end for the posit Lorenz DDA: parameter load, run/halt, state snapshots.
// Optional build macro DDA_CTRL_AUTOSTREAM_EN: stream a snapshot on every DDA step while idle.
module dda_ctrl
  import dda_ctrl_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned NPARAM = 7,
  parameter int unsigned NSTATE = 3,
  parameter logic [NPARAM*N-1:0] DEFAULTS = (NPARAM*N)'(DEFAULT_LORENZ_16)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [NPARAM*N-1:0]   params,
  output logic                  dda_en,
  output logic                  dda_load,
  input  logic [NSTATE*N-1:0]   state_in,
`ifdef DDA_CTRL_AUTOSTREAM_EN
  input  logic                  state_step,
  output logic [7:0]            ovf_cnt,
`endif
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err
);

  localparam int unsigned PW  = NPARAM * N;
  localparam int unsigned BPW = N / 8;
  localparam int unsigned NPB = PW / 8;
  localparam int unsigned CW  = (NPB > 1) ? $clog2(NPB) : 1;
  localparam int unsigned SW  = (PW > 1) ? $clog2(PW) : 1;

  ctrl_state_e   state, state_n;
  logic [PW-1:0] shadow, shadow_n, params_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] lsb_c;
  logic          run_flag, run_n;
  logic          en_n, load_n, err_n;
  logic          snap_c, ser_done_c;
`ifdef DDA_CTRL_AUTOSTREAM_EN
  logic [7:0]    ovf_n;
`endif

  assign cmd_ready = (state != ST_STREAM);
  assign lsb_c     = SW'(load_byte_lsb(32'(cnt), BPW));

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    params_n = params;
    cnt_n    = cnt;
    run_n    = run_flag;
    en_n     = dda_en;
    load_n   = 1'b0;
    err_n    = err;
    snap_c   = 1'b0;
`ifdef DDA_CTRL_AUTOSTREAM_EN
    ovf_n    = ovf_cnt;
    if (state_step && state != ST_IDLE && ovf_cnt != 8'hFF) ovf_n = ovf_cnt + 8'd1;
`endif
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_data)
            OP_RUN:  en_n = 1'b1;
            OP_HALT: en_n = 1'b0;
            OP_LOAD: begin
              run_n   = dda_en;
              en_n    = 1'b0;
              cnt_n   = '0;
              state_n = ST_LOAD;
            end
            OP_SNAP: begin
              snap_c  = 1'b1;
              state_n = ST_STREAM;
            end
            default: err_n = 1'b1;
          endcase
        end
`ifdef DDA_CTRL_AUTOSTREAM_EN
        else if (state_step && dda_en) begin
          snap_c  = 1'b1;
          state_n = ST_STREAM;
        end
`endif
      end
      ST_LOAD: begin
        if (cmd_valid) begin
          shadow_n[lsb_c +: 8] = cmd_data;
          // Final byte: publish the merged image in one step.
          if (cnt == CW'(NPB - 1)) begin
            params_n = shadow_n;
            load_n   = 1'b1;
            en_n     = run_flag;
            state_n  = ST_IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      ST_STREAM: begin
        if (ser_done_c) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shadow   <= DEFAULTS;
      params   <= DEFAULTS;
      cnt      <= '0;
      run_flag <= 1'b1;
      dda_en   <= 1'b1;
      dda_load <= 1'b0;
      err      <= 1'b0;
`ifdef DDA_CTRL_AUTOSTREAM_EN
      ovf_cnt  <= 8'd0;
`endif
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      params   <= params_n;
      cnt      <= cnt_n;
      run_flag <= run_n;
      dda_en   <= en_n;
      dda_load <= load_n;
      err      <= err_n;
`ifdef DDA_CTRL_AUTOSTREAM_EN
      ovf_cnt  <= ovf_n;
`endif
    end
  end

  dda_byte_ser #(.W(N), .NW(NSTATE)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (snap_c),
    .din       (state_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done_c    (ser_done_c)
  );

endmodule

// File: tb/tb_dda_ctrl.sv
// Scoreboard bench for dda_ctrl: directed commands, expected stream bytes queued and checked by a monitor.
module tb_dda_ctrl;

  localparam logic [111:0] DEF   = 112'h0400_7300_5555_6A00_7240_14CD_C000;
  localparam logic [111:0] IMG_A = 112'h0400_7300_5555_6A00_7240_14CD_4000;

  logic         clk;
  logic         rst_n;
  logic [7:0]   cmd_data;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [111:0] params;
  logic         dda_en;
  logic         dda_load;
  logic [47:0]  state_in;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         err;
`ifdef DDA_CTRL_AUTOSTREAM_EN
  logic         state_step;
  logic [7:0]   ovf_cnt;
  initial state_step = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic       prev_stall;
  logic [7:0] prev_data;

  logic [7:0] load_a [14] = '{8'h40, 8'h00, 8'h14, 8'hCD, 8'h72, 8'h40, 8'h6A,
                              8'h00, 8'h55, 8'h55, 8'h73, 8'h00, 8'h04, 8'h00};
  logic [7:0] load_d [14] = '{8'hC0, 8'h00, 8'h14, 8'hCD, 8'h72, 8'h40, 8'h6A,
                              8'h00, 8'h55, 8'h55, 8'h73, 8'h00, 8'h04, 8'h00};

  dda_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .params     (params),
    .dda_en     (dda_en),
    .dda_load   (dda_load),
    .state_in   (state_in),
`ifdef DDA_CTRL_AUTOSTREAM_EN
    .state_step (state_step),
    .ovf_cnt    (ovf_cnt),
`endif
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte and hold it until accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got no handshake required cmd_ready within 100 cycles");
    end
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] bytes [14], input logic [111:0] old_img,
                         input logic [111:0] new_img, input logic exp_en);
    send_byte(8'h01);
    chk("load_entry_en", 128'(dda_en), 128'(1'b0));
    for (int k = 0; k < 14; k++) begin
      send_byte(bytes[k]);
      if (k < 13) begin
        chk("params_no_partial", 128'(params), 128'(old_img));
        chk("dda_en_during_load", 128'(dda_en), 128'(1'b0));
        tick(1);
      end
    end
    chk("params_commit", 128'(params), 128'(new_img));
    chk("dda_load_pulse", 128'(dda_load), 128'(1'b1));
    chk("dda_en_restore", 128'(dda_en), 128'(exp_en));
    tick(1);
    chk("dda_load_one_cycle", 128'(dda_load), 128'(1'b0));
    chk("dda_en_after_load", 128'(dda_en), 128'(exp_en));
  endtask

  task automatic wait_drain(input bit toggle);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL stream_drain: got %0d bytes outstanding required 0", sb.size());
    end
  endtask

  // Monitor: pop on every output handshake, and check data holds while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && prev_stall) chk("out_hold", 128'(out_data), 128'(prev_data));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got byte %h required no output", out_data);
        end else begin
          chk("stream_byte", 128'(out_data), 128'(sb.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    out_ready = 1'b0;
    state_in  = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    chk("rst_params", 128'(params), 128'(DEF));
    chk("rst_dda_en", 128'(dda_en), 128'(1'b1));
    chk("rst_dda_load", 128'(dda_load), 128'(1'b0));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_data", 128'(out_data), 128'(8'h00));
    chk("rst_err", 128'(err), 128'(1'b0));
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));

    // LOAD new icx while running
    do_load(load_a, DEF, IMG_A, 1'b1);

    // HALT then LOAD: enable stays off
    send_byte(8'h03);
    chk("halt_en", 128'(dda_en), 128'(1'b0));
    do_load(load_d, IMG_A, DEF, 1'b0);

    // SNAP with stalling downstream and a post-capture state change
    state_in = {16'h7240, 16'h14CD, 16'hC000};
    sb.push_back(8'hC0); sb.push_back(8'h00); sb.push_back(8'h14);
    sb.push_back(8'hCD); sb.push_back(8'h72); sb.push_back(8'h40);
    send_byte(8'h04);
    state_in = 48'hDEAD_BEEF_1234;
    chk("snap_latency_valid", 128'(out_valid), 128'(1'b1));
    chk("stream_cmd_ready", 128'(cmd_ready), 128'(1'b0));
    wait_drain(1'b1);
    out_ready = 1'b0;
    tick(2);
    chk("stream_end_valid", 128'(out_valid), 128'(1'b0));
    chk("stream_end_ready", 128'(cmd_ready), 128'(1'b1));

    // Back-to-back SNAPs
    out_ready = 1'b1;
    state_in = {16'h0102, 16'h0304, 16'h0506};
    sb.push_back(8'h05); sb.push_back(8'h06); sb.push_back(8'h03);
    sb.push_back(8'h04); sb.push_back(8'h01); sb.push_back(8'h02);
    send_byte(8'h04);
    state_in = {16'hA1A2, 16'hB1B2, 16'hC1C2};
    sb.push_back(8'hC1); sb.push_back(8'hC2); sb.push_back(8'hB1);
    sb.push_back(8'hB2); sb.push_back(8'hA1); sb.push_back(8'hA2);
    send_byte(8'h04);
    chk("snap2_valid", 128'(out_valid), 128'(1'b1));
    wait_drain(1'b0);
    tick(2);
    chk("snap2_end_valid", 128'(out_valid), 128'(1'b0));

    // Illegal opcode: sticky err, stays IDLE, RUN still decoded
    send_byte(8'h55);
    chk("illegal_err", 128'(err), 128'(1'b1));
    chk("illegal_idle", 128'(cmd_ready), 128'(1'b1));
    chk("illegal_no_stream", 128'(out_valid), 128'(1'b0));
    send_byte(8'h02);
    chk("run_after_illegal", 128'(dda_en), 128'(1'b1));
    chk("err_sticky", 128'(err), 128'(1'b1));

    // Reset in the middle of a LOAD
    send_byte(8'h01);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h11 * (k + 1)));
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("midload_rst_params", 128'(params), 128'(DEF));
    chk("midload_rst_en", 128'(dda_en), 128'(1'b1));
    chk("midload_rst_err", 128'(err), 128'(1'b0));
    chk("midload_rst_ready", 128'(cmd_ready), 128'(1'b1));
    send_byte(8'h55);
    chk("post_rst_opcode", 128'(err), 128'(1'b1));
    chk("post_rst_params", 128'(params), 128'(DEF));
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dda_ctrl.md
Name: dda_ctrl

Overview:
- Byte-serial control front-end for the posit Lorenz DDA core; replaces the fixed reset-loaded parameter bytes of the current top.
- Accepts opcodes and parameter bytes over an 8-bit valid/ready stream and holds parameters in a shadow/active register pair with atomic commit.
- Controls the DDA enable and reload, and streams snapshots of the state variables out byte-wise.
- Generalised in word width, parameter count and state-variable count.

Parameters:
- N, 16, posit word width in bits; must be a multiple of 8.
- NPARAM, 7, number of N-bit parameter words (icx, icy, icz, sigma, beta, rho, dt).
- NSTATE, 3, number of N-bit state variables (x, y, z).
- DEFAULTS, 112'h0400_7300_5555_6A00_7240_14CD_C000, reset parameter image; word k occupies bits [(k+1)*N-1:k*N].

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_data  in  8  opcode/parameter byte
- cmd_valid  in  1  cmd_data valid
- cmd_ready  out  1  byte accepted when cmd_valid&&cmd_ready
- params  out  NPARAM*N  active parameter image to DDA
- dda_en  out  1  DDA step enable
- dda_load  out  1  one-cycle pulse: DDA reloads initial conditions
- state_in  in  NSTATE*N  live DDA state; word k at [(k+1)*N-1:k*N]
- state_step  in  1  pulse, DDA completed one integration step
- out_data  out  8  streamed state byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- err  out  1  sticky: illegal opcode seen

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- Opcodes: 0x01 LOAD, 0x02 RUN, 0x03 HALT, 0x04 SNAP; every other opcode is illegal.
- Reset (rst_n=0 at posedge):
  - params=DEFAULTS, shadow=DEFAULTS.
  - dda_en=1, dda_load=0, out_valid=0, out_data=0, err=0.
  - FSM=IDLE, byte counter=0.
  - Reset mid-LOAD discards partial shadow contents. Reset mid-STREAM drops the stream.
- States: IDLE, LOAD, STREAM.
- IDLE: cmd_ready=1; on opcode accept:
  - RUN -> dda_en<=1.
  - HALT -> dda_en<=0.
  - LOAD -> remember run flag, dda_en<=0, cnt<=0, go LOAD.
  - SNAP -> snapshot register<=state_in on the same edge, go STREAM.
  - Illegal -> err<=1, stay IDLE.
- LOAD:
  - cmd_ready=1; each accepted byte is written to shadow.
  - Order: word 0 first, MSB byte first; total NPARAM*N/8 bytes.
  - On the final byte: params<=shadow atomically; dda_load pulses high for exactly the next cycle; dda_en restored to the remembered flag; go IDLE.
  - params never shows a partial image.
- STREAM:
  - cmd_ready=0.
  - out_valid=1 from the cycle after entry, data = snapshot word 0 MSB first, NSTATE*N/8 bytes total.
  - out_data is held stable while out_valid && !out_ready.
  - After the last handshake: out_valid=0, IDLE on the next cycle.
  - Back-to-back SNAP: at least one idle cycle between streams.
- Latency: opcode accept -> first out_valid is 1 cycle; final LOAD byte -> params updated is 1 cycle, with dda_load in that same cycle.
- state_step is ignored unless the optional feature is compiled in.
- Counters are sized $clog2 of the byte total; wrap never occurs because the FSM exits on the terminal count.

Optional Feature:
- Macro: DDA_CTRL_AUTOSTREAM_EN.
- Defined:
  - A state_step pulse while dda_en=1 and FSM=IDLE with no cmd handshake in that cycle captures state_in and enters STREAM exactly as SNAP.
  - A cmd handshake in the same cycle wins and the step is dropped.
  - A step arriving outside IDLE is dropped; it increments an 8-bit saturating overrun port ovf_cnt (output, reset 0).
- Undefined: state_step and the ovf_cnt port are absent; streaming happens only via SNAP.

Decomposition:
- Package dda_ctrl_pkg: opcode constants OP_LOAD/OP_RUN/OP_HALT/OP_SNAP, FSM state enum, DEFAULT_LORENZ_16 constant.
- One sub-module, dda_byte_ser: parallel-load NSTATE*N-bit shift register plus valid/ready byte output and last-byte flag.

Test Plan:
- Reset then idle: params=DEFAULTS, dda_en=1, out_valid=0, err=0.
- LOAD of 14 bytes (new icx=0x4000, others unchanged), with cmd_valid gaps: params is unchanged until the 14th byte; the next cycle shows word0=0x4000, dda_load high for exactly 1 cycle, and dda_en=1 restored.
- HALT, LOAD, final byte: dda_en stays 0 throughout and after.
- SNAP with state_in={z=0x7240,y=0x14CD,x=0xC000} and out_ready toggling 1/0: bytes C0,00,14,CD,72,40 in order; data is held while stalled; state_in changes after capture do not affect the stream.
- Opcode 0x55: err=1 and sticky; the FSM stays IDLE; a subsequent RUN still works.
- rst_n low mid-LOAD (after 5 bytes), then release: params=DEFAULTS, FSM IDLE, and the next byte is decoded as an opcode.
